// File: rtl/kronos_dmem.sv
// Word-addressed data memory with a req/gnt handshake and WAIT_STATES extra cycles before each grant.
// Optional out-of-range error strobe under `KRONOS_DMEM_ERR_EN`; without it, addresses alias modulo DEPTH.
module kronos_dmem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic [31:0] data_rd_data,
  output logic        data_gnt
`ifdef KRONOS_DMEM_ERR_EN
  ,
  output logic        data_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        wr_q, wr_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] mem [DEPTH];

  logic        req;
  logic        enter_resp;
  logic [31:0] acc_addr, acc_wdat, acc_off;
  logic        acc_wr;
  logic [AW-1:0] acc_idx;
  logic        acc_oor;

  assign req = data_rd_req | data_wr_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = data_addr;
          wdat_d = data_wr_data;
          wr_d   = data_wr_req;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the RESP-entry edge is also the accept edge, so use the live inputs then.
  assign enter_resp = (state_d == RESP);
  assign acc_addr   = (state_q == IDLE) ? data_addr    : addr_q;
  assign acc_wdat   = (state_q == IDLE) ? data_wr_data : wdat_q;
  assign acc_wr     = (state_q == IDLE) ? data_wr_req  : wr_q;
  assign acc_off    = acc_addr - BASE_ADDR;
  assign acc_idx    = AW'(acc_off >> 2);

`ifdef KRONOS_DMEM_ERR_EN
  logic err_q;
  assign acc_oor  = (acc_off >> (AW + 2)) != 32'd0;
  assign data_err = err_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) err_q <= 1'b0;
    else       err_q <= enter_resp & acc_oor;
  end
`else
  assign acc_oor = 1'b0;
`endif

  always_comb begin
    rdat_d = rdat_q;
    if (enter_resp && !acc_wr) rdat_d = acc_oor ? 32'h0 : mem[acc_idx];
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdat_q  <= 32'h0;
      wr_q    <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage is never reset; the rstz term blocks a write on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (rstz && enter_resp && acc_wr && !acc_oor) mem[acc_idx] <= acc_wdat;
  end

  assign data_rd_data = rdat_q;
  assign data_gnt     = (state_q == RESP);

endmodule

// File: tb/tb_kronos_dmem.sv
// Scoreboard bench for kronos_dmem: one instance with no wait states, one with three.
module tb_kronos_dmem;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rd [2];
  logic        wr [2];
  logic        gnt [2];
`ifdef KRONOS_DMEM_ERR_EN
  logic        err [2];
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  kronos_dmem #(.WAIT_STATES(0)) u_dmem0 (
    .clk(clk), .rstz(rstz), .data_addr(addr[0]), .data_wr_data(wdat[0]),
    .data_rd_req(rd[0]), .data_wr_req(wr[0]), .data_rd_data(rdat[0]), .data_gnt(gnt[0])
`ifdef KRONOS_DMEM_ERR_EN
    , .data_err(err[0])
`endif
  );

  kronos_dmem #(.WAIT_STATES(3)) u_dmem3 (
    .clk(clk), .rstz(rstz), .data_addr(addr[1]), .data_wr_data(wdat[1]),
    .data_rd_req(rd[1]), .data_wr_req(wr[1]), .data_rd_data(rdat[1]), .data_gnt(gnt[1])
`ifdef KRONOS_DMEM_ERR_EN
    , .data_err(err[1])
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m0[int];
  logic [31:0] m1[int];
  logic [31:0] last_rd [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'h1000) >> 2) & 32'h3FF);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef KRONOS_DMEM_ERR_EN
    return (a - 32'h1000) >= 32'h1000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Grants are matched in order against what the model predicted when the request was driven.
  always @(negedge clk) begin
    if (rstz) begin
      for (int d = 0; d < 2; d++) begin
        if (gnt[d]) begin
          exp_t e;
          if (qsize(d) == 0) begin
            check($sformatf("spurious_gnt%0d", d), 32'd1, 32'd0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("gnt_cycle%0d", d), 32'(cyc), 32'(e.cyc));
            check($sformatf("rd_data%0d", d), rdat[d], e.rd);
`ifdef KRONOS_DMEM_ERR_EN
            check($sformatf("err%0d", d), 32'(err[d]), 32'(e.err));
`endif
          end
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after a rising edge one idle cycle past the grant.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] v, input bit hold);
    exp_t e;
    bit   bad;
    int   k;
    bad   = out_of_range(a);
    e.cyc = cyc + 1 + ws(d);
    e.err = bad;
    if (w) begin
      if (!bad) begin
        if (d == 0) m0[widx(a)] = v;
        else        m1[widx(a)] = v;
      end
      e.rd = last_rd[d];
    end else begin
      if (bad)         e.rd = 32'h0;
      else if (d == 0) e.rd = m0[widx(a)];
      else             e.rd = m1[widx(a)];
      last_rd[d] = e.rd;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    addr[d] = a; wdat[d] = v; rd[d] = r; wr[d] = w;
    for (int i = 1; i <= ws(d) + 1; i++) begin
      @(posedge clk); #1;
      if (!hold || i == ws(d) + 1) begin
        rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = a + 32'd4; wdat[d] = $urandom;
      end
    end
    k = 0;
    while (qsize(d) != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (qsize(d) != 0) begin
      check($sformatf("gnt_timeout%0d", d), 32'(qsize(d)), 32'd0);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, v;
    rstz = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'h0; wdat[d] = 32'h0; rd[d] = 1'b0; wr[d] = 1'b0; last_rd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'd0);
      check($sformatf("rst_rd_data%0d", d), rdat[d], 32'd0);
`ifdef KRONOS_DMEM_ERR_EN
      check($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
`endif
    end
    @(posedge clk); #1;
    rstz = 1'b1;
    @(posedge clk); #1;

    // Basic write then read, both request lines high treated as a write, and post-accept changes ignored.
    access(0, 0, 1, 32'h1000, 32'hDEADBEEF, 0);
    access(0, 1, 0, 32'h1000, 32'h0, 0);
    access(0, 0, 1, 32'h1008, 32'h55AA55AA, 0);
    access(0, 1, 1, 32'h1004, 32'h12345678, 0);
    access(0, 1, 0, 32'h1004, 32'h0, 0);
    access(0, 1, 0, 32'h1008, 32'h0, 0);

    // Out-of-range accesses: dropped with err when checking is built in, aliased otherwise.
    access(0, 0, 1, 32'h2000, 32'hCAFEF00D, 0);
    access(0, 1, 0, 32'h1000, 32'h0, 0);
    access(0, 1, 0, 32'h2000, 32'h0, 0);
    access(0, 0, 1, 32'h0FFC, 32'hA5A5_0001, 0);
    access(0, 1, 0, 32'h0FFC, 32'h0, 0);
    access(0, 1, 0, 32'h1FFC, 32'h0, 0);

    // Three wait states with the request held through the wait.
    access(1, 0, 1, 32'h1010, 32'h0BAD_F00D, 1);
    access(1, 1, 0, 32'h1010, 32'h0, 1);
    access(1, 1, 0, 32'h1010, 32'h0, 0);

    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        a = 32'h1000 + 32'(4 * $urandom_range(1000, 16));
        v = $urandom;
        access(d, 0, 1, a, v, i[0]);
        access(d, 1, 0, a, 32'h0, i[0]);
      end
    end

    // Reset during the wait of a write aborts it: no grant, old contents kept, outputs cleared.
    access(1, 0, 1, 32'h1020, 32'h1111_2222, 0);
    access(1, 1, 0, 32'h1020, 32'h0, 0);
    addr[1] = 32'h1020; wdat[1] = 32'h3333_4444; wr[1] = 1'b1;
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(posedge clk); #1;
    rstz = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_gnt%0d", d), 32'(gnt[d]), 32'd0);
      check($sformatf("abort_rd_data%0d", d), rdat[d], 32'd0);
      last_rd[d] = 32'h0;
    end
    @(posedge clk); #1;
    rstz = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    access(1, 1, 0, 32'h1020, 32'h0, 0);
    access(0, 1, 0, 32'h1004, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
